// File: rtl/xgmii_frame_gen_if.sv
// XGMII transmit bus bundle: one data byte and one control bit per lane.
// Latency: none, this is wiring only.
// Backpressure: none; the XGMII bus has no ready signal.
interface xgmii_frame_gen_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] xgmii_txd;
  logic [CTRL_WIDTH-1:0] xgmii_txc;

  modport master (output xgmii_txd, output xgmii_txc);
  modport slave  (input  xgmii_txd, input  xgmii_txc);
endinterface

// File: rtl/xgmii_frame_gen.sv
// XGMII TX frame source: preamble, counted payload, lane-correct terminate, idle gap.
// Latency: registered outputs; start in cycle N gives the first preamble word in cycle N+1.
// Backpressure: none; the bus is free-running and words are emitted every cycle.
module xgmii_frame_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16,
  parameter int IPG_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [IPG_WIDTH-1:0] cfg_ipg,
  input  logic [CNT_WIDTH-1:0] cfg_frames,
  xgmii_frame_gen_if.master    xgmii,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] frames_sent
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int PRE_WORDS = 8 / LANES;
  // Start, six preamble bytes and SFD; byte 0 goes out first (lane 0).
  localparam logic [63:0] PRE_SEQ = 64'hD5555555555555FB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_TERM,
    S_IPG
  } state_t;

  state_t                 state_q, state_d;
  logic [0:0]             pre_idx_q, pre_idx_d;
  logic [LEN_WIDTH-1:0]   byte_pos_q, byte_pos_d;
  logic [IPG_WIDTH-1:0]   ipg_idx_q, ipg_idx_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [IPG_WIDTH-1:0]   ipg_q, ipg_d;
  logic [CNT_WIDTH-1:0]   frames_q, frames_d;
  logic [CNT_WIDTH-1:0]   sent_q, sent_d;
  logic                   stop_seen_q, stop_seen_d;
  logic [DATA_WIDTH-1:0]  txd_q, txd_d;
  logic [CTRL_WIDTH-1:0]  txc_q, txc_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [LEN_WIDTH-1:0]   remaining;
  logic [CNT_WIDTH-1:0]   sent_inc;
  logic [LEN_WIDTH:0]     pos;

  // State and output registers; reset forces idles and clears every counter.
  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      state_q     <= S_IDLE;
      pre_idx_q   <= '0;
      byte_pos_q  <= '0;
      ipg_idx_q   <= '0;
      len_q       <= '0;
      ipg_q       <= '0;
      frames_q    <= '0;
      sent_q      <= '0;
      stop_seen_q <= 1'b0;
      txd_q       <= {LANES{8'h07}};
      txc_q       <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_idx_q   <= pre_idx_d;
      byte_pos_q  <= byte_pos_d;
      ipg_idx_q   <= ipg_idx_d;
      len_q       <= len_d;
      ipg_q       <= ipg_d;
      frames_q    <= frames_d;
      sent_q      <= sent_d;
      stop_seen_q <= stop_seen_d;
      txd_q       <= txd_d;
      txc_q       <= txc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next state and counters, then the bus word belonging to the next state.
  always_comb begin
    state_d     = state_q;
    pre_idx_d   = pre_idx_q;
    byte_pos_d  = byte_pos_q;
    ipg_idx_d   = ipg_idx_q;
    len_d       = len_q;
    ipg_d       = ipg_q;
    frames_d    = frames_q;
    sent_d      = sent_q;
    stop_seen_d = stop_seen_q;
    done_d      = 1'b0;
    txd_d       = {LANES{8'h07}};
    txc_d       = '1;
    pos         = '0;
    remaining   = len_q - byte_pos_q;
    sent_inc    = sent_q + CNT_WIDTH'(1);

    case (state_q)
      S_IDLE: begin
        // stop alone is ignored here; with start it limits the run to one frame.
        if (start) begin
          state_d     = S_PRE;
          pre_idx_d   = '0;
          len_d       = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
          ipg_d       = (cfg_ipg == '0) ? IPG_WIDTH'(1) : cfg_ipg;
          frames_d    = cfg_frames;
          sent_d      = '0;
          stop_seen_d = stop;
        end
      end
      S_PRE: begin
        stop_seen_d = stop_seen_q | stop;
        if (pre_idx_q == 1'(PRE_WORDS - 1)) begin
          state_d    = S_DATA;
          byte_pos_d = '0;
        end else begin
          pre_idx_d = pre_idx_q + 1'b1;
        end
      end
      S_DATA: begin
        stop_seen_d = stop_seen_q | stop;
        if (remaining > LEN_WIDTH'(LANES)) begin
          byte_pos_d = byte_pos_q + LEN_WIDTH'(LANES);
        end else if (remaining == LEN_WIDTH'(LANES)) begin
          // Payload filled the word exactly, so the terminate needs its own word.
          state_d = S_TERM;
        end else begin
          // This word already carried the terminate after the tail bytes.
          state_d   = S_IPG;
          ipg_idx_d = '0;
        end
      end
      S_TERM: begin
        stop_seen_d = stop_seen_q | stop;
        state_d     = S_IPG;
        ipg_idx_d   = '0;
      end
      S_IPG: begin
        if (ipg_idx_q == ipg_q - IPG_WIDTH'(1)) begin
          sent_d = sent_inc;
          if (((frames_q != '0) && (sent_inc == frames_q)) || stop_seen_q || stop) begin
            state_d     = S_IDLE;
            done_d      = 1'b1;
            stop_seen_d = 1'b0;
          end else begin
            state_d     = S_PRE;
            pre_idx_d   = '0;
            stop_seen_d = 1'b0;
          end
        end else begin
          ipg_idx_d   = ipg_idx_q + IPG_WIDTH'(1);
          stop_seen_d = stop_seen_q | stop;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Word generation; the completed-frame count doubles as the frame index.
    case (state_d)
      S_PRE: begin
        for (int i = 0; i < LANES; i++) begin
          txd_d[i*8 +: 8] = PRE_SEQ[(int'(pre_idx_d) * LANES + i) * 8 +: 8];
          txc_d[i]        = (pre_idx_d == 1'b0) && (i == 0);
        end
      end
      S_DATA: begin
        for (int i = 0; i < LANES; i++) begin
          pos = {1'b0, byte_pos_d} + (LEN_WIDTH + 1)'(i);
          if (pos < {1'b0, len_d}) begin
            txd_d[i*8 +: 8] = pos[7:0] + sent_d[7:0];
            txc_d[i]        = 1'b0;
          end else if (pos == {1'b0, len_d}) begin
            txd_d[i*8 +: 8] = 8'hFD;
          end
        end
      end
      S_TERM: begin
        txd_d[7:0] = 8'hFD;
      end
      default: begin
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign xgmii.xgmii_txd = txd_q;
  assign xgmii.xgmii_txc = txc_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign frames_sent     = sent_q;

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// Scoreboard bench for the XGMII frame source at 64-bit and 32-bit widths.
// Stimulus pushes expected bus words and done counts; negedge monitors pop and compare.
// Every wait on the DUT is bounded by a cycle budget.
module tb_xgmii_frame_gen;

  logic        tx_clk = 1'b0;
  logic        tx_rst_n;
  logic        start64, start32, stop;
  logic [15:0] cfg_len;
  logic [7:0]  cfg_ipg;
  logic [15:0] cfg_frames;
  logic        busy64, done64, busy32, done32;
  logic [15:0] fs64, fs32;

  always #5 tx_clk = ~tx_clk;

  xgmii_frame_gen_if #(.DATA_WIDTH(64)) bus64 ();
  xgmii_frame_gen_if #(.DATA_WIDTH(32)) bus32 ();

  xgmii_frame_gen #(.DATA_WIDTH(64)) dut64 (
    .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .start(start64), .stop(stop),
    .cfg_len(cfg_len), .cfg_ipg(cfg_ipg), .cfg_frames(cfg_frames),
    .xgmii(bus64), .busy(busy64), .done(done64), .frames_sent(fs64)
  );

  xgmii_frame_gen #(.DATA_WIDTH(32)) dut32 (
    .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .start(start32), .stop(stop),
    .cfg_len(cfg_len), .cfg_ipg(cfg_ipg), .cfg_frames(cfg_frames),
    .xgmii(bus32), .busy(busy32), .done(done32), .frames_sent(fs32)
  );

  localparam logic [71:0] IDLE64 = {8'hff, {8{8'h07}}};
  localparam logic [35:0] IDLE32 = {4'hf, {4{8'h07}}};

  int n_cmp = 0;
  int n_bad = 0;

  logic [71:0] exp64[$];
  logic [35:0] exp32[$];
  logic [15:0] done_q64[$];
  logic [15:0] done_q32[$];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %s, expected the DUT event (t=%0t)", name, what, $time);
  endtask

  // Reference frame: byte stream of preamble, payload, FD, 07 padding, then idle words.
  task automatic push_frame64(input int len, input int ipg, input int idx);
    logic [7:0]  b[$];
    logic        c[$];
    logic [63:0] wd;
    logic [7:0]  wc;
    int l, g;
    l = (len == 0) ? 1 : len;
    g = (ipg == 0) ? 1 : ipg;
    b.push_back(8'hFB); c.push_back(1'b1);
    for (int k = 0; k < 6; k++) begin b.push_back(8'h55); c.push_back(1'b0); end
    b.push_back(8'hD5); c.push_back(1'b0);
    for (int k = 0; k < l; k++) begin b.push_back(8'(k + idx)); c.push_back(1'b0); end
    b.push_back(8'hFD); c.push_back(1'b1);
    while (b.size() % 8 != 0) begin b.push_back(8'h07); c.push_back(1'b1); end
    for (int w = 0; w < b.size() / 8; w++) begin
      for (int i = 0; i < 8; i++) begin
        wd[i*8 +: 8] = b[w*8 + i];
        wc[i]        = c[w*8 + i];
      end
      exp64.push_back({wc, wd});
    end
    for (int k = 0; k < g; k++) exp64.push_back(IDLE64);
  endtask

  task automatic go64(input int len, input int ipg, input int frames, input logic with_stop);
    cfg_len = 16'(len); cfg_ipg = 8'(ipg); cfg_frames = 16'(frames);
    @(posedge tx_clk); #1;
    start64 = 1'b1; stop = with_stop;
    @(posedge tx_clk); #1;
    start64 = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_done64(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge tx_clk);
      if (done64) seen = 1'b1;
    end
    if (!seen) fail_now(name, "timeout");
    repeat (3) @(posedge tx_clk);
  endtask

  task automatic wait_sent64(input string name, input logic [15:0] val, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge tx_clk);
      if (fs64 == val) seen = 1'b1;
    end
    if (!seen) fail_now(name, "timeout");
  endtask

  // 64-bit monitor: busy words come from the scoreboard, otherwise the bus must idle.
  always @(negedge tx_clk) begin
    if (tx_rst_n === 1'b1) begin
      if (busy64) begin
        if (exp64.size() == 0) fail_now("word64", "unexpected busy word");
        else check("word64", {bus64.xgmii_txc, bus64.xgmii_txd}, exp64.pop_front());
      end else begin
        check("idle64", {bus64.xgmii_txc, bus64.xgmii_txd}, IDLE64);
      end
      if (done64) begin
        if (done_q64.size() == 0) fail_now("done64", "unexpected done pulse");
        else check("done64 frames_sent", 72'(fs64), 72'(done_q64.pop_front()));
      end
    end
  end

  // 32-bit monitor, same rules.
  always @(negedge tx_clk) begin
    if (tx_rst_n === 1'b1) begin
      if (busy32) begin
        if (exp32.size() == 0) fail_now("word32", "unexpected busy word");
        else check("word32", 72'({bus32.xgmii_txc, bus32.xgmii_txd}), 72'(exp32.pop_front()));
      end else begin
        check("idle32", 72'({bus32.xgmii_txc, bus32.xgmii_txd}), 72'(IDLE32));
      end
      if (done32) begin
        if (done_q32.size() == 0) fail_now("done32", "unexpected done pulse");
        else check("done32 frames_sent", 72'(fs32), 72'(done_q32.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of stimulus, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tx_rst_n = 1'b0; start64 = 1'b0; start32 = 1'b0; stop = 1'b0;
    cfg_len = 16'd0; cfg_ipg = 8'd0; cfg_frames = 16'd0;
    repeat (3) @(posedge tx_clk);
    #1 tx_rst_n = 1'b1;
    @(negedge tx_clk);
    check("reset txd/txc", {bus64.xgmii_txc, bus64.xgmii_txd}, IDLE64);
    check("reset busy", 72'(busy64), 72'(0));
    check("reset done", 72'(done64), 72'(0));
    check("reset frames_sent", 72'(fs64), 72'(0));

    // len=16: two full data words, separate terminate word.
    exp64.push_back({8'h01, 64'hd5555555555555fb});
    exp64.push_back({8'h00, 64'h0706050403020100});
    exp64.push_back({8'h00, 64'h0f0e0d0c0b0a0908});
    exp64.push_back({8'hff, 64'h07070707070707fd});
    exp64.push_back(IDLE64);
    done_q64.push_back(16'd1);
    go64(16, 1, 1, 1'b0);
    wait_done64("run len16", 50);

    // len=20: terminate shares the tail word.
    exp64.push_back({8'h01, 64'hd5555555555555fb});
    exp64.push_back({8'h00, 64'h0706050403020100});
    exp64.push_back({8'h00, 64'h0f0e0d0c0b0a0908});
    exp64.push_back({8'hf0, 64'h070707fd13121110});
    exp64.push_back(IDLE64);
    done_q64.push_back(16'd1);
    go64(20, 1, 1, 1'b0);
    wait_done64("run len20", 50);
    check("frames_sent holds", 72'(fs64), 72'(1));

    // Three frames; a mid-run start and cfg change must be ignored.
    for (int f = 0; f < 3; f++) push_frame64(8, 2, f);
    done_q64.push_back(16'd3);
    go64(8, 2, 3, 1'b0);
    repeat (2) @(posedge tx_clk);
    #1 cfg_len = 16'd99; start64 = 1'b1;
    @(posedge tx_clk); #1 start64 = 1'b0;
    wait_done64("run 3 frames", 100);

    // Zero length and zero gap behave as one.
    exp64.push_back({8'h01, 64'hd5555555555555fb});
    exp64.push_back({8'hfe, 64'h070707070707fd00});
    exp64.push_back(IDLE64);
    done_q64.push_back(16'd1);
    go64(0, 0, 1, 1'b0);
    wait_done64("run len0", 50);

    // Continuous run stopped during the second frame's payload.
    push_frame64(64, 1, 0);
    push_frame64(64, 1, 1);
    done_q64.push_back(16'd2);
    go64(64, 1, 0, 1'b0);
    wait_sent64("stop wait frame1", 16'd1, 100);
    repeat (3) @(posedge tx_clk);
    #1 stop = 1'b1;
    @(posedge tx_clk); #1 stop = 1'b0;
    wait_done64("run stop", 100);
    repeat (20) @(posedge tx_clk);

    // stop together with start sends exactly one frame.
    push_frame64(8, 1, 0);
    done_q64.push_back(16'd1);
    go64(8, 1, 0, 1'b1);
    wait_done64("run start+stop", 50);
    repeat (10) @(posedge tx_clk);

    // Reset mid-payload of the second continuous frame.
    push_frame64(16, 1, 0);
    push_frame64(16, 1, 1);
    go64(16, 1, 0, 1'b0);
    wait_sent64("reset wait frame1", 16'd1, 100);
    @(posedge tx_clk); #1 tx_rst_n = 1'b0;
    @(posedge tx_clk); #1 tx_rst_n = 1'b1;
    exp64.delete();
    @(negedge tx_clk);
    check("after reset busy", 72'(busy64), 72'(0));
    check("after reset frames_sent", 72'(fs64), 72'(0));
    check("after reset txd/txc", {bus64.xgmii_txc, bus64.xgmii_txd}, IDLE64);
    push_frame64(16, 1, 0);
    done_q64.push_back(16'd1);
    go64(16, 1, 1, 1'b0);
    wait_done64("run after reset", 50);

    // 32-bit instance, len=5.
    exp32.push_back({4'h1, 32'h555555fb});
    exp32.push_back({4'h0, 32'hd5555555});
    exp32.push_back({4'h0, 32'h03020100});
    exp32.push_back({4'he, 32'h0707fd04});
    exp32.push_back({4'hf, 32'h07070707});
    done_q32.push_back(16'd1);
    cfg_len = 16'd5; cfg_ipg = 8'd1; cfg_frames = 16'd1;
    @(posedge tx_clk); #1 start32 = 1'b1;
    @(posedge tx_clk); #1 start32 = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge tx_clk);
        if (done32) seen = 1'b1;
      end
      if (!seen) fail_now("run32 len5", "timeout");
    end
    repeat (5) @(posedge tx_clk);

    check("exp64 drained", 72'(exp64.size()), 72'(0));
    check("exp32 drained", 72'(exp32.size()), 72'(0));
    check("done64 drained", 72'(done_q64.size()), 72'(0));
    check("done32 drained", 72'(done_q32.size()), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
